maze_dfs_ctrl: RTL
==================

Name: maze_dfs_ctrl

Overview:
- Depth-first maze-search sequencer for the location stack. It walks a grid of up to 16x16 cells, reads wall bits from the maze memory and keeps a visited map.
- It drives the stack's push/pop/locIn/done/run pins and backtracks on dead ends.
- On reaching the goal it flips the stack into queue mode and replays the found path as moves.

Parameters:
- MAZE_W, 16, grid width in cells (1..16); X range 0..MAZE_W-1.
- MAZE_H, 16, grid height in cells (1..16); Y range 0..MAZE_H-1.
- MAX_STEPS, 1024, search aborts with fail after this many stack pushes; counter is 16-bit.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- startLoc  in  8  start cell {X[7:4],Y[3:0]}; sampled on start.
- goalLoc  in  8  goal cell; sampled on start.
- wallAddr  out  8  maze memory read address {X,Y}.
- wallRd  out  1  read strobe.
- wallData  in  1  1 = wall/blocked; valid the cycle after wallRd.
- stkClr  out  1  drives stack rst; one-cycle pulse at search start.
- stkPush  out  1  stack push.
- stkPop  out  1  stack pop.
- stkLocIn  out  8  location to push.
- stkLocOut  in  8  stack locOut; valid the cycle after stkPop.
- stkEmpty  in  1  stack empStck.
- stkDone  out  1  one-cycle pulse that switches the stack to queue mode.
- stkRun  out  1  high during replay.
- busy  out  1  high outside IDLE/END.
- found  out  1  sticky; goal reached.
- fail  out  1  sticky; no path or step limit hit.

Behaviour:
- Reset: state=IDLE. All outputs 0. Visited map cleared. Internal cur, goal and step counter = 0.
- Reset has priority in every state, including mid-search and mid-replay.
- IDLE: on start, latch startLoc/goalLoc, clear found/fail and the visited map, zero the step counter, go to CLEAR.
- CLEAR: stkClr=1 for 1 cycle -> PUSH_START.
- PUSH_START: stkPush=1, stkLocIn=start; cur=start; mark start visited; step=1. If start==goal -> DONE_PULSE; else SCAN with dir=0.
- Direction order, dir 0..3: E(X+1), S(Y+1), W(X-1), N(Y-1). Arithmetic is 4-bit. Any neighbour that wraps or lies beyond MAZE_W-1 / MAZE_H-1 is out of bounds.
- SCAN (1 cycle per dir):
  - Neighbour out of bounds or already visited: dir+1 next cycle.
  - Otherwise: wallRd=1, wallAddr=neighbour -> RDWAIT.
  - dir==3 exhausted with no candidate -> BACK_POP.
- RDWAIT:
  - wallData=1: dir+1 -> SCAN, or BACK_POP if dir was 3.
  - wallData=0: stkPush=1, stkLocIn=nb; mark nb visited; cur=nb; step+1; dir=0.
  - After that push: nb==goal -> DONE_PULSE; step==MAX_STEPS -> END with fail=1; else SCAN.
- BACK_POP: stkPop=1 (discards cur) -> PARENT_POP.
- PARENT_POP: stkEmpty=1 -> END with fail=1. Otherwise stkPop=1 -> PARENT_PUSH.
- PARENT_PUSH: cur=stkLocOut; stkPush=1, stkLocIn=stkLocOut; dir=0 -> SCAN. The re-push does not increment step.
- DONE_PULSE: stkDone=1 for 1 cycle; found=1 -> REPLAY.
- REPLAY: stkRun=1. stkPop=1 every cycle while stkEmpty=0. The first cycle with stkEmpty=1 -> END.
- END: busy=0, found/fail held, stkRun=0. Returns to IDLE the next cycle; a new start is then accepted.
- start is ignored while busy.
- stkPush and stkPop are never high in the same cycle. stkDone is never high with push/pop.
- Visited map: 256 flops, indexed by {X,Y}; cells outside MAZE_W x MAZE_H are never marked.

Optional Feature:
- Macro MAZE_STEP_CNT_EN.
- Defined: adds output port stepCnt [15:0] = current step counter (pushes excluding parent re-pushes). It holds its value in END and clears on start or rst.
- Undefined: port absent. The counter exists only for the MAX_STEPS check, with identical behaviour.

Test Plan:
- 4x4 all-open maze, MAZE_W=MAZE_H=4, start=8'h00, goal=8'h30 -> pushes 00,10,20,30; found=1; stkDone one pulse; REPLAY pops until stkEmpty; fail=0.
- start=goal=8'h55 -> one push, stkDone on the next cycle, found=1, no wallRd ever issued.
- 4x4 maze, start 00, goal 33, goal fully walled -> every reachable cell visited; the stack empties in PARENT_POP; fail=1, found=0, stkDone never asserted.
- Dead-end branch: E from 00 leads to a walled 10 -> 11 pocket, path S from 00 -> BACK_POP/PARENT_POP/PARENT_PUSH sequence observed; re-pushed location equals the parent; goal still found.
- rst asserted in RDWAIT mid-search -> next cycle all outputs 0, state IDLE, visited map cleared; a new start restarts cleanly.
- MAX_STEPS=3, open 16x16 maze, start 00, goal FF -> fail=1 right after the 3rd push; with MAZE_STEP_CNT_EN, stepCnt=3.

Source files
------------

// File: rtl/maze_dfs_ctrl.sv
// Depth-first maze search sequencer driving a location stack, with path replay.
// Define MAZE_STEP_CNT_EN to expose the step counter on port stepCnt.
module maze_dfs_ctrl #(
   parameter int MAZE_W    = 16,
   parameter int MAZE_H    = 16,
   parameter int MAX_STEPS = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] startLoc,
   input  logic [7:0] goalLoc,
   output logic [7:0] wallAddr,
   output logic       wallRd,
   input  logic       wallData,
   output logic       stkClr,
   output logic       stkPush,
   output logic       stkPop,
   output logic [7:0] stkLocIn,
   input  logic [7:0] stkLocOut,
   input  logic       stkEmpty,
   output logic       stkDone,
   output logic       stkRun,
   output logic       busy,
   output logic       found,
   output logic       fail
`ifdef MAZE_STEP_CNT_EN
   ,
   output logic [15:0] stepCnt
`endif
);

   typedef enum logic [3:0] {
      S_IDLE, S_CLEAR, S_PUSH_START, S_SCAN, S_RDREQ, S_RDWAIT, S_CHECK,
      S_BACK_POP, S_PARENT_POP, S_PARENT_RD, S_PARENT_PUSH,
      S_DONE_PULSE, S_REPLAY, S_END
   } state_t;

   state_t       state;
   logic [7:0]   cur;
   logic [7:0]   goal;
   logic [15:0]  step;
   logic [1:0]   dir;
   logic [255:0] visited;
   logic         pop_q;
   logic [4:0]   nx;
   logic [4:0]   ny;
   logic [7:0]   nb;
   logic         nb_ok;
   logic         start_in;

`ifdef MAZE_STEP_CNT_EN
   assign stepCnt = step;
`endif

   // 5-bit neighbour coordinates so wrap-around lands out of range
   always_comb begin
      nx = {1'b0, cur[7:4]};
      ny = {1'b0, cur[3:0]};
      unique case (dir)
         2'd0:    nx = nx + 5'd1;
         2'd1:    ny = ny + 5'd1;
         2'd2:    nx = nx - 5'd1;
         default: ny = ny - 5'd1;
      endcase
      nb    = {nx[3:0], ny[3:0]};
      nb_ok = (nx < 5'(MAZE_W)) && (ny < 5'(MAZE_H)) && !visited[nb];
   end

   assign start_in = ({1'b0, cur[7:4]} < 5'(MAZE_W)) &&
                     ({1'b0, cur[3:0]} < 5'(MAZE_H));

   // replay pops must track stkEmpty in the same cycle
   assign stkPop = pop_q | ((state == S_REPLAY) && !stkEmpty);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cur      <= '0;
         goal     <= '0;
         step     <= '0;
         dir      <= '0;
         visited  <= '0;
         wallAddr <= '0;
         wallRd   <= 1'b0;
         stkClr   <= 1'b0;
         stkPush  <= 1'b0;
         pop_q    <= 1'b0;
         stkLocIn <= '0;
         stkDone  <= 1'b0;
         stkRun   <= 1'b0;
         busy     <= 1'b0;
         found    <= 1'b0;
         fail     <= 1'b0;
      end else begin
         wallRd  <= 1'b0;
         stkClr  <= 1'b0;
         stkPush <= 1'b0;
         pop_q   <= 1'b0;
         stkDone <= 1'b0;
         unique case (state)
            S_IDLE: if (start) begin
               cur     <= startLoc;
               goal    <= goalLoc;
               found   <= 1'b0;
               fail    <= 1'b0;
               visited <= '0;
               step    <= '0;
               dir     <= '0;
               busy    <= 1'b1;
               stkClr  <= 1'b1;
               state   <= S_CLEAR;
            end
            S_CLEAR: begin
               stkPush  <= 1'b1;
               stkLocIn <= cur;
               if (start_in) visited[cur] <= 1'b1;
               step  <= 16'd1;
               dir   <= '0;
               state <= S_PUSH_START;
            end
            S_PUSH_START: begin
               if (cur == goal) begin
                  stkDone <= 1'b1;
                  found   <= 1'b1;
                  state   <= S_DONE_PULSE;
               end else begin
                  state <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (nb_ok) begin
                  wallRd   <= 1'b1;
                  wallAddr <= nb;
                  state    <= S_RDREQ;
               end else if (dir == 2'd3) begin
                  pop_q <= 1'b1;
                  state <= S_BACK_POP;
               end else begin
                  dir <= dir + 2'd1;
               end
            end
            S_RDREQ: state <= S_RDWAIT;
            S_RDWAIT: begin
               if (wallData) begin
                  if (dir == 2'd3) begin
                     pop_q <= 1'b1;
                     state <= S_BACK_POP;
                  end else begin
                     dir   <= dir + 2'd1;
                     state <= S_SCAN;
                  end
               end else begin
                  stkPush           <= 1'b1;
                  stkLocIn          <= wallAddr;
                  visited[wallAddr] <= 1'b1;
                  cur               <= wallAddr;
                  step              <= step + 16'd1;
                  dir               <= '0;
                  state             <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (cur == goal) begin
                  stkDone <= 1'b1;
                  found   <= 1'b1;
                  state   <= S_DONE_PULSE;
               end else if (step >= 16'(MAX_STEPS)) begin
                  fail  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_END;
               end else begin
                  state <= S_SCAN;
               end
            end
            S_BACK_POP: state <= S_PARENT_POP;
            S_PARENT_POP: begin
               if (stkEmpty) begin
                  fail  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_END;
               end else begin
                  pop_q <= 1'b1;
                  state <= S_PARENT_RD;
               end
            end
            S_PARENT_RD: state <= S_PARENT_PUSH;
            S_PARENT_PUSH: begin
               cur      <= stkLocOut;
               stkPush  <= 1'b1;
               stkLocIn <= stkLocOut;
               dir      <= '0;
               state    <= S_SCAN;
            end
            S_DONE_PULSE: begin
               stkRun <= 1'b1;
               state  <= S_REPLAY;
            end
            S_REPLAY: if (stkEmpty) begin
               stkRun <= 1'b0;
               busy   <= 1'b0;
               state  <= S_END;
            end
            S_END: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
